radix4_mul_seq: RTL
===================

RADIX4_MUL_SEQ -- requirements
Module: radix4_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the unsigned operand width; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand pair present.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-007 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-008 SHALL have port out_valid  output  1  product available.
REQ-009 SHALL have port out_ready  input  1  consumer takes product.
REQ-010 SHALL have port p  output  2*WIDTH  unsigned product a*b.
REQ-011 SHALL have port sel  output  2  current radix-4 digit driving the partial-product select.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready high only in IDLE.
REQ-014 SHALL accept operands on an edge with in_valid and in_ready both high, latching a, b, and the precomputed 3a (WIDTH+2 bits), clearing the accumulator and digit counter, and moving to RUN.
REQ-015 SHALL, in RUN, set sel to b_shift[1:0] and select the partial product 0, a, 2a or 3a for sel 00, 01, 10 or 11.
REQ-016 SHALL, on each RUN edge, add the selected partial product shifted left by 2*count into the 2*WIDTH accumulator, shift b_shift right by 2, and increment count.
REQ-017 SHALL leave RUN after exactly WIDTH/2 edges and enter DONE; the accumulator is never truncated because the maximum product fits in 2*WIDTH bits.
REQ-018 SHALL hold out_valid high and p stable throughout DONE, and assert out_valid at no other time.
REQ-019 SHALL return to IDLE on the edge where out_valid and out_ready are both high; in_ready rises in the following cycle, so no operand is accepted in that same cycle.
REQ-020 SHALL ignore in_valid in RUN and DONE, leaving operands unlatched.
REQ-021 SHALL give a latency of WIDTH/2+1 edges from the accept edge to out_valid observed high (9 for WIDTH=16), giving a throughput of one product per WIDTH/2+2 cycles with out_ready held high.
REQ-022 SHALL drive sel to 00 in IDLE and DONE.
REQ-023 SHALL behave identically when a or b is zero: full WIDTH/2 iterations, result 0, with no early exit.
REQ-024 SHALL ignore out_ready outside DONE.

Reset
REQ-025 SHALL, with rst high at an edge, enter IDLE with in_ready=1 after the edge, out_valid=0, p=0, sel=00, count=0, and accumulator=0.
REQ-026 SHALL let rst override every other input in any state, including mid-RUN and DONE; any partial result is discarded and no out_valid follows.
REQ-027 SHALL keep the reset purely synchronous, with no asynchronous path from rst to state.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, RUN, DONE), the radix constant 2 bits per digit, and the digit-select encodings in the shared multiplier package.
REQ-029 SHALL instantiate one sub-module, pp_select, that is combinational and WIDTH+2 bits wide, mapping sel to 0, a, 2a or 3a; the adder, shifters and FSM remain in radix4_mul_seq.
REQ-030 SHALL be register-bounded with no combinational path from in_valid or out_ready to p.

Verification
REQ-031 SHALL cover: WIDTH=16, a=3, b=5, out_ready=1 -> out_valid high 9 edges after accept, p=15, sel sequence 01,01,00,00,00,00,00,00.
REQ-032 SHALL cover: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001, with sel=11 on all 8 RUN cycles.
REQ-033 SHALL cover: out_ready low for 5 cycles after out_valid -> p and out_valid held for those 5 cycles, and in_ready stays low until 1 cycle after the handshake.
REQ-034 SHALL cover: in_valid held high with new operands during RUN -> those operands are ignored; the first product is unchanged, and the second pair is accepted only after returning to IDLE.
REQ-035 SHALL cover: rst pulsed for 1 cycle at RUN count 4 -> next cycle shows in_ready=1, out_valid=0, p=0; a following a=7, b=9 yields p=63.
REQ-036 SHALL cover: a=0x1234, b=0 -> p=0 after the full 9-edge latency.

Source files
------------

// File: rtl/radix4_mul_seq_pkg.sv
// rtl/radix4_mul_seq_pkg.sv - shared FSM, radix and digit-select encodings for the radix-4 multiplier
package radix4_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int RADIX_BITS = 2;

  localparam logic [RADIX_BITS-1:0] SEL_ZERO = 2'b00;
  localparam logic [RADIX_BITS-1:0] SEL_A    = 2'b01;
  localparam logic [RADIX_BITS-1:0] SEL_2A   = 2'b10;
  localparam logic [RADIX_BITS-1:0] SEL_3A   = 2'b11;

endpackage

// File: rtl/radix4_mul_seq_if.sv
// rtl/radix4_mul_seq_if.sv - operand/product handshake bundle for the radix-4 multiplier
interface radix4_mul_seq_if #(parameter int WIDTH = 16);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic [1:0]           sel;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, sel
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, sel
  );

endinterface

// File: rtl/radix4_mul_seq_pp_select.sv
// rtl/radix4_mul_seq_pp_select.sv - combinational radix-4 partial-product mux (0, a, 2a, 3a)
module pp_select
  import radix4_mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [RADIX_BITS-1:0] sel,
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH+1:0]      a3,
  output logic [WIDTH+1:0]      pp
);

  always_comb begin
    pp = '0;
    case (sel)
      SEL_ZERO: pp = '0;
      SEL_A:    pp = {2'b00, a};
      SEL_2A:   pp = {1'b0, a, 1'b0};
      SEL_3A:   pp = a3;
      default:  pp = '0;
    endcase
  end

endmodule

// File: rtl/radix4_mul_seq.sv
// rtl/radix4_mul_seq.sv - sequential unsigned radix-4 multiplier, one 2-bit digit per RUN cycle
module radix4_mul_seq
  import radix4_mul_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  radix4_mul_seq_if.slave bus
);

  localparam int DIGITS = WIDTH / RADIX_BITS;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH+1:0]     a3_reg;
  logic [WIDTH-1:0]     b_shift;
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     count;

  logic [RADIX_BITS-1:0] sel_cur;
  logic [WIDTH+1:0]      pp;
  logic [2*WIDTH-1:0]    pp_ext;
  logic                  accept;
  logic                  step;

  pp_select #(.WIDTH(WIDTH)) u_pp_select (
    .sel (sel_cur),
    .a   (a_reg),
    .a3  (a3_reg),
    .pp  (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    sel_cur        = SEL_ZERO;
    accept         = 1'b0;
    step           = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        sel_cur = b_shift[RADIX_BITS-1:0];
        step    = 1'b1;
        if (count == LAST_CNT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The top digit lands at bit 2*WIDTH-1 at most, so the 2*WIDTH accumulator never overflows.
  assign pp_ext = {{(WIDTH-2){1'b0}}, pp} << {count, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      a3_reg  <= '0;
      b_shift <= '0;
      acc     <= '0;
      count   <= '0;
    end else if (accept) begin
      a_reg   <= bus.a;
      a3_reg  <= {2'b00, bus.a} + {1'b0, bus.a, 1'b0};
      b_shift <= bus.b;
      acc     <= '0;
      count   <= '0;
    end else if (step) begin
      acc     <= acc + pp_ext;
      b_shift <= b_shift >> RADIX_BITS;
      count   <= count + CNT_W'(1);
    end
  end

  assign bus.p   = acc;
  assign bus.sel = sel_cur;

endmodule
